// File: rtl/elevator_sched_pkg.sv
// Shared types and default sizing for the elevator call scheduler.
package elevator_sched_pkg;

    localparam int unsigned DEF_NUM_FLOORS = 10;
    localparam int unsigned DEF_FLOOR_W    = 4;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        DISPATCH,
        TRAVEL,
        DWELL,
        HALT
    } state_e;

endpackage

// File: rtl/elevator_look_select.sv
// LOOK pick: nearest pending floor ahead in the sweep direction, else nearest behind (reversing).
module elevator_look_select
    import elevator_sched_pkg::*;
#(
    parameter int unsigned NUM_FLOORS = DEF_NUM_FLOORS,
    parameter int unsigned FLOOR_W    = DEF_FLOOR_W
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    pos_floor,
    input  logic                  dir_up,
    output logic                  found,
    output logic [FLOOR_W-1:0]    floor,
    output logic                  dir_up_next,
    output logic                  here
);

    logic               w_up_found;
    logic               w_dn_found;
    logic [FLOOR_W-1:0] w_up_floor;
    logic [FLOOR_W-1:0] w_dn_floor;

    // Downward scan leaves the lowest floor above; upward scan leaves the highest floor below.
    always_comb begin
        w_up_found = 1'b0;
        w_up_floor = '0;
        w_dn_found = 1'b0;
        w_dn_floor = '0;
        for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
            if (pending[i] && (FLOOR_W'(i) > pos_floor)) begin
                w_up_found = 1'b1;
                w_up_floor = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (pending[i] && (FLOOR_W'(i) < pos_floor)) begin
                w_dn_found = 1'b1;
                w_dn_floor = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        found       = 1'b0;
        floor       = '0;
        dir_up_next = dir_up;
        here        = |(pending & (NUM_FLOORS'(1) << pos_floor));
        if (dir_up) begin
            if (w_up_found) begin
                found = 1'b1;
                floor = w_up_floor;
            end else if (w_dn_found) begin
                found       = 1'b1;
                floor       = w_dn_floor;
                dir_up_next = 1'b0;
            end
        end else begin
            if (w_dn_found) begin
                found = 1'b1;
                floor = w_dn_floor;
            end else if (w_up_found) begin
                found       = 1'b1;
                floor       = w_up_floor;
                dir_up_next = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Call capture, LOOK target sequencing and door dwell timing for one car.
// Optional PEAK_PARK_EN adds park_en: an idle car away from floor 0 returns there with doors shut.
module elevator_call_scheduler
    import elevator_sched_pkg::*;
#(
    parameter int unsigned NUM_FLOORS   = DEF_NUM_FLOORS,
    parameter int unsigned FLOOR_W      = DEF_FLOOR_W,
    parameter int unsigned DWELL_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] car_req,
    input  logic [NUM_FLOORS-1:0] hall_up_req,
    input  logic [NUM_FLOORS-1:0] hall_dn_req,
    input  logic [FLOOR_W-1:0]    pos_floor,
    input  logic                  emer_stop,
    input  logic                  arrive,
`ifdef PEAK_PARK_EN
    input  logic                  park_en,
`endif
    output logic                  target_valid,
    output logic [FLOOR_W-1:0]    target_floor,
    input  logic                  target_ready,
    output logic                  door_open,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  busy
);

    localparam int unsigned CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL_CYCLES - 1);

    state_e                r_state, w_state_nxt;
    logic [NUM_FLOORS-1:0] r_car, r_up, r_dn;
    logic [NUM_FLOORS-1:0] w_pending, w_pos_mask;
    logic [NUM_FLOORS-1:0] w_clr_car, w_clr_up, w_clr_dn;
    logic                  r_dir_up, w_dir_nxt;
    logic [FLOOR_W-1:0]    r_tgt, w_tgt_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic                  r_park, w_park_nxt;
    logic                  r_tv, r_door, r_busy;
    logic                  w_found, w_look_dir, w_here, w_ahead, w_clr_en, w_press_here;
    logic [FLOOR_W-1:0]    w_floor;

    assign w_pending    = r_car | r_up | r_dn;
    assign w_pos_mask   = NUM_FLOORS'(1) << pos_floor;
    assign w_press_here = |((car_req | hall_up_req | hall_dn_req) & w_pos_mask);

    elevator_look_select #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_look (
        .pending     (w_pending),
        .pos_floor   (pos_floor),
        .dir_up      (r_dir_up),
        .found       (w_found),
        .floor       (w_floor),
        .dir_up_next (w_look_dir),
        .here        (w_here)
    );

    // A call lies ahead exactly when LOOK finds one without reversing.
    assign w_ahead   = w_found && (w_look_dir == r_dir_up);
    assign w_clr_en  = (w_state_nxt == DWELL);
    assign w_clr_car = w_clr_en ? w_pos_mask : '0;
    assign w_clr_up  = (w_clr_en && (r_dir_up || !w_ahead)) ? w_pos_mask : '0;
    assign w_clr_dn  = (w_clr_en && (!r_dir_up || !w_ahead)) ? w_pos_mask : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir_up;
        w_tgt_nxt   = r_tgt;
        w_cnt_nxt   = r_cnt;
        w_park_nxt  = r_park;
        if (emer_stop) begin
            w_state_nxt = HALT;
            w_park_nxt  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_here) begin
                        w_state_nxt = DWELL;
                        w_cnt_nxt   = CNT_LOAD;
                    end else if (|w_pending) begin
                        w_state_nxt = SELECT;
                    end
`ifdef PEAK_PARK_EN
                    else if (park_en && (pos_floor != '0)) begin
                        w_state_nxt = DISPATCH;
                        w_tgt_nxt   = '0;
                        w_park_nxt  = 1'b1;
                    end
`endif
                end
                SELECT: begin
                    if (w_here) begin
                        w_state_nxt = DWELL;
                        w_cnt_nxt   = CNT_LOAD;
                    end else if (w_found) begin
                        w_state_nxt = DISPATCH;
                        w_tgt_nxt   = w_floor;
                        w_dir_nxt   = w_look_dir;
                        w_park_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                DISPATCH: begin
                    if (target_ready) w_state_nxt = TRAVEL;
                end
                TRAVEL: begin
                    if (arrive) begin
                        w_park_nxt = 1'b0;
                        if (r_park) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = DWELL;
                            w_cnt_nxt   = CNT_LOAD;
                        end
                    end
                end
                DWELL: begin
                    if (w_press_here) begin
                        w_cnt_nxt = CNT_LOAD;
                    end else if (r_cnt == '0) begin
                        w_state_nxt = (|w_pending) ? SELECT : IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                HALT:    w_state_nxt = SELECT;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_car    <= '0;
            r_up     <= '0;
            r_dn     <= '0;
            r_dir_up <= 1'b1;
            r_tgt    <= '0;
            r_cnt    <= '0;
            r_park   <= 1'b0;
            r_tv     <= 1'b0;
            r_door   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_car    <= (r_car | car_req) & ~w_clr_car;
            r_up     <= (r_up | hall_up_req) & ~w_clr_up;
            r_dn     <= (r_dn | hall_dn_req) & ~w_clr_dn;
            r_dir_up <= w_dir_nxt;
            r_tgt    <= w_tgt_nxt;
            r_cnt    <= w_cnt_nxt;
            r_park   <= w_park_nxt;
            r_tv     <= (w_state_nxt == DISPATCH);
            r_door   <= (w_state_nxt == DWELL) || (w_state_nxt == HALT);
            r_busy   <= (w_state_nxt != IDLE);
        end
    end

    assign target_valid = r_tv;
    assign target_floor = r_tgt;
    assign door_open    = r_door;
    assign dir_up       = r_dir_up;
    assign pending      = w_pending;
    assign busy         = r_busy;

endmodule
